// File: rtl/ysyx_22041461_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IFU,
// read-only) and load/store (LSU, read/write). One transaction in flight.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   ifu_req_*/ifu_addr   IFU read request (valid/ready)
//   ifu_rsp_*            IFU registered response: 1-cycle valid, data, timeout err
//   lsu_req_*/lsu_*      LSU request (valid/ready) with wen/wdata/wmask
//   lsu_rsp_*            LSU registered response: 1-cycle valid, data, timeout err
//   mem_req_*/mem_*      latched request towards memory (valid/ready)
//   mem_rsp_valid/data   memory response, accepted only while waiting for it
//   busy                 arbiter is not idle
module ysyx_22041461_mem_arbiter #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [63:0] ifu_addr,
  output logic        ifu_rsp_valid,
  output logic [63:0] ifu_rsp_data,
  output logic        ifu_rsp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [63:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [63:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_rsp_valid,
  output logic [63:0] lsu_rsp_data,
  output logic        lsu_rsp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_wen,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [63:0] mem_rsp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        last_lsu_q, last_lsu_d;    // last grant went to the LSU
  logic        owner_lsu_q, owner_lsu_d;  // current transaction belongs to the LSU
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic        ifu_vld_q, ifu_vld_d, ifu_err_q, ifu_err_d;
  logic        lsu_vld_q, lsu_vld_d, lsu_err_q, lsu_err_d;
  logic [63:0] ifu_data_q, ifu_data_d, lsu_data_q, lsu_data_d;

  logic grant_ifu, grant_lsu, accept, expired, rsp_ok, rsp_to;

  // Arbitration: a lone requester wins; under contention the one not granted last time wins.
  always_comb begin
    grant_lsu = (state_q == IDLE) && lsu_req_valid && (!ifu_req_valid || !last_lsu_q);
    grant_ifu = (state_q == IDLE) && ifu_req_valid && !grant_lsu;
    accept    = grant_ifu || grant_lsu;
    // Counter saturates at CNT_LAST, so a handshake on the final REQ cycle still
    // leaves WAIT with an expired budget (a response in that cycle wins).
    expired   = (cnt_q == CNT_LAST);
    rsp_ok    = (state_q == WAIT) && mem_rsp_valid;
    rsp_to    = expired && (((state_q == REQ) && !mem_req_ready) ||
                            ((state_q == WAIT) && !mem_rsp_valid));
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ:     if (mem_req_ready) state_d = WAIT;
               else if (rsp_to)   state_d = IDLE;
      WAIT:    if (rsp_ok || rsp_to) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ifu_req_ready = grant_ifu;
    lsu_req_ready = grant_lsu;
    mem_req_valid = (state_q == REQ);
    busy          = (state_q != IDLE);
    mem_addr      = addr_q;
    mem_wen       = wen_q;
    mem_wdata     = wdata_q;
    mem_wmask     = wmask_q;
    ifu_rsp_valid = ifu_vld_q;
    ifu_rsp_data  = ifu_data_q;
    ifu_rsp_err   = ifu_err_q;
    lsu_rsp_valid = lsu_vld_q;
    lsu_rsp_data  = lsu_data_q;
    lsu_rsp_err   = lsu_err_q;
  end

  // Request latch, watchdog and response datapath
  always_comb begin
    last_lsu_d  = last_lsu_q;
    owner_lsu_d = owner_lsu_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wen_d       = wen_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    ifu_vld_d   = 1'b0;
    ifu_err_d   = 1'b0;
    ifu_data_d  = '0;
    lsu_vld_d   = 1'b0;
    lsu_err_d   = 1'b0;
    lsu_data_d  = '0;

    if (state_q != IDLE && !expired) cnt_d = cnt_q + 1'b1;

    if (accept) begin
      last_lsu_d  = grant_lsu;
      owner_lsu_d = grant_lsu;
      cnt_d       = '0;
      addr_d      = grant_lsu ? lsu_addr  : ifu_addr;
      wen_d       = grant_lsu && lsu_wen;
      wdata_d     = grant_lsu ? lsu_wdata : '0;
      wmask_d     = grant_lsu ? lsu_wmask : '0;
    end

    if (rsp_ok) begin
      if (owner_lsu_q) begin
        lsu_vld_d  = 1'b1;
        lsu_data_d = wen_q ? '0 : mem_rsp_data;
      end else begin
        ifu_vld_d  = 1'b1;
        ifu_data_d = mem_rsp_data;
      end
    end else if (rsp_to) begin
      if (owner_lsu_q) begin
        lsu_vld_d = 1'b1;
        lsu_err_d = 1'b1;
      end else begin
        ifu_vld_d = 1'b1;
        ifu_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_lsu_q  <= 1'b1;
      owner_lsu_q <= 1'b0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      ifu_vld_q   <= 1'b0;
      ifu_err_q   <= 1'b0;
      ifu_data_q  <= '0;
      lsu_vld_q   <= 1'b0;
      lsu_err_q   <= 1'b0;
      lsu_data_q  <= '0;
    end else begin
      last_lsu_q  <= last_lsu_d;
      owner_lsu_q <= owner_lsu_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      ifu_vld_q   <= ifu_vld_d;
      ifu_err_q   <= ifu_err_d;
      ifu_data_q  <= ifu_data_d;
      lsu_vld_q   <= lsu_vld_d;
      lsu_err_q   <= lsu_err_d;
      lsu_data_q  <= lsu_data_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_mem_arbiter.sv
module tb_ysyx_22041461_mem_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_err;
  logic [63:0] ifu_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_err;
  logic [63:0] lsu_addr, lsu_wdata, lsu_rsp_data;
  logic [7:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, busy;
  logic [63:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [7:0]  mem_wmask;

  int checks = 0;
  int errors = 0;
  bit model_last_lsu;  // reference: who received the previous grant

  ysyx_22041461_mem_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data), .ifu_rsp_err(ifu_rsp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  // One transaction, entered and left on a falling edge with the arbiter idle.
  // rd: REQ cycles before mem_req_ready; sd: WAIT cycles before mem_rsp_valid.
  // Budget model: success iff the response lands within TO cycles of REQ+WAIT.
  task automatic txn(input bit iv, input bit lv, input bit hold,
                     input logic [63:0] ia, input logic [63:0] la, input bit lw,
                     input logic [63:0] lwd, input logic [7:0] lwm,
                     input int rd, input int sd, input logic [63:0] rw);
    bit gl, ew, ph, done, eerr;
    logic [63:0] ea, ewd, edata;
    logic [7:0] ewm;
    int c;
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
    #1;
    gl = lv && (!iv || !model_last_lsu);
    chk("ifu_req_ready_grant", ifu_req_ready, iv && !gl);
    chk("lsu_req_ready_grant", lsu_req_ready, gl);
    model_last_lsu = gl;
    ea  = gl ? la : ia;
    ew  = gl && lw;
    ewd = gl ? lwd : 64'd0;
    ewm = gl ? lwm : 8'd0;
    @(negedge clk);
    if (!hold) begin ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; end
    c = 0; ph = 0; done = 0; eerr = 0;
    while (!done) begin
      chk("busy_in_txn", busy, 1);
      chk("ifu_ready_busy", ifu_req_ready, 0);
      chk("lsu_ready_busy", lsu_req_ready, 0);
      chk("ifu_rsp_idle", ifu_rsp_valid, 0);
      chk("lsu_rsp_idle", lsu_rsp_valid, 0);
      chk("mem_req_valid", mem_req_valid, !ph);
      if (!ph) begin
        chk("mem_addr", mem_addr, ea);
        chk("mem_wen", mem_wen, ew);
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_wmask", mem_wmask, ewm);
      end
      // Scramble request inputs: the latched fields must not follow them.
      ifu_addr = r64(); lsu_addr = r64(); lsu_wdata = r64(); lsu_wmask = 8'($urandom);
      mem_req_ready = !ph && (c == rd);
      // Responses during REQ (even alongside mem_req_ready) are stray.
      mem_rsp_valid = ph ? (c == rd + 1 + sd) : 1'($urandom);
      mem_rsp_data  = (ph && c == rd + 1 + sd) ? rw : r64();
      @(negedge clk);
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      if (!ph) begin
        if (c == rd) ph = 1;
        else if (c == TO - 1) begin done = 1; eerr = 1; end
      end else if (c == rd + 1 + sd) done = 1;
      else if (c >= TO - 1) begin done = 1; eerr = 1; end
      c++;
    end
    edata = (eerr || ew) ? 64'd0 : rw;
    chk("busy_rsp_cycle", busy, 0);
    chk("mem_req_valid_rsp", mem_req_valid, 0);
    chk("ifu_rsp_valid", ifu_rsp_valid, !gl);
    chk("ifu_rsp_err", ifu_rsp_err, !gl && eerr);
    chk("ifu_rsp_data", ifu_rsp_data, gl ? 64'd0 : edata);
    chk("lsu_rsp_valid", lsu_rsp_valid, gl);
    chk("lsu_rsp_err", lsu_rsp_err, gl && eerr);
    chk("lsu_rsp_data", lsu_rsp_data, gl ? edata : 64'd0);
  endtask

  initial begin
    bit iv, lv;
    int rd, sd;
    rst = 1'b1;
    ifu_req_valid = 0; ifu_addr = 0;
    lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    model_last_lsu = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wmask", mem_wmask, 0);
    chk("rst_ifu_rsp", {ifu_rsp_valid, ifu_rsp_err}, 0);
    chk("rst_lsu_rsp", {lsu_rsp_valid, lsu_rsp_err}, 0);
    chk("rst_ifu_data", ifu_rsp_data, 0);
    chk("rst_lsu_data", lsu_rsp_data, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Contention from reset: both held valid, grants alternate starting with IFU.
    for (int i = 0; i < 4; i++)
      txn(1, 1, 1, r64(), r64(), 1'($urandom), r64(), 8'($urandom), 0, 0, r64());
    ifu_req_valid = 0; lsu_req_valid = 0;

    // Single IFU read at minimum latency.
    txn(1, 0, 0, 64'h8000_0000, 0, 0, 0, 0, 0, 0, 64'h0000_0000_0041_0113);

    // LSU write with mem_req_ready delayed 5 cycles.
    txn(0, 1, 0, 0, 64'h8000_0010, 1, 64'h1122_3344_5566_7788, 8'h0F, 5, 1, r64());

    // Watchdog: no acceptance, then no response, then a normal read.
    txn(1, 0, 0, r64(), 0, 0, 0, 0, 100, 0, r64());
    txn(1, 0, 0, r64(), 0, 0, 0, 0, 2, 100, r64());
    txn(1, 0, 0, r64(), 0, 0, 0, 0, 0, 0, r64());

    // Stray responses while idle.
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = r64();
      @(negedge clk);
      chk("stray_ifu_rsp", ifu_rsp_valid, 0);
      chk("stray_lsu_rsp", lsu_rsp_valid, 0);
      chk("stray_busy", busy, 0);
    end
    mem_rsp_valid = 1'b0;

    // Response on the last budget cycle wins over the timeout.
    txn(0, 1, 0, 0, r64(), 0, 0, 0, 4, 10, r64());
    txn(1, 0, 0, r64(), 0, 0, 0, 0, 0, 14, r64());

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      iv = 1'($urandom); lv = 1'($urandom);
      if (!iv && !lv) iv = 1'b1;
      rd = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 6);
      sd = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, 6);
      txn(iv, lv, 1'($urandom), r64(), r64(), 1'($urandom), r64(), 8'($urandom), rd, sd, r64());
    end
    ifu_req_valid = 0; lsu_req_valid = 0;
    @(negedge clk);

    // Asynchronous reset while waiting for a response.
    ifu_req_valid = 1'b1; ifu_addr = r64();
    @(negedge clk);
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_mem_req_valid", mem_req_valid, 0);
    chk("async_rst_mem_addr", mem_addr, 0);
    chk("async_rst_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_last_lsu = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_data = r64();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    end
    mem_rsp_valid = 1'b0;
    txn(1, 1, 0, r64(), r64(), 1, r64(), 8'hFF, 1, 1, r64());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/ysyx_22041461_mem_arbiter.md
Name: ysyx_22041461_mem_arbiter

Overview:
- Round-robin arbiter that shares one memory port between instruction fetch (IFU, read-only) and load/store (LSU, read/write).
- Needed for the multi-cycle core, where fetch and data access no longer have separate ports.
- Handles one outstanding transaction at a time, using valid/ready requests, registered responses and a watchdog timeout.

Parameters:
- TIMEOUT, 256: cycles a granted transaction may stay in REQ+WAIT before it is aborted with an error.
- CNT_W, 8: width of the watchdog counter; TIMEOUT must be ≤ 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  64  IFU read address.
- ifu_rsp_valid  out  1  IFU response, 1-cycle pulse.
- ifu_rsp_data  out  64  IFU read data.
- ifu_rsp_err  out  1  IFU response is a timeout error.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  64  LSU address.
- lsu_wen  in  1  1 = write, 0 = read.
- lsu_wdata  in  64  LSU write data.
- lsu_wmask  in  8  byte-enable mask for writes.
- lsu_rsp_valid  out  1  LSU response, 1-cycle pulse (reads and writes).
- lsu_rsp_data  out  64  LSU read data (0 for writes).
- lsu_rsp_err  out  1  LSU response is a timeout error.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepted the request.
- mem_addr  out  64  latched address.
- mem_wen  out  1  latched write enable (always 0 for IFU).
- mem_wdata  out  64  latched write data.
- mem_wmask  out  8  latched write mask (8'h00 for IFU).
- mem_rsp_valid  in  1  memory response.
- mem_rsp_data  in  64  memory read data.
- busy  out  1  asserted when state != IDLE.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE, last_grant = LSU, owner = IFU, counter = 0.
  - All latched request fields = 0.
  - All rsp_valid/rsp_err/rsp_data = 0; mem_req_valid = 0, busy = 0.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - Arbitration:
    - Only one valid: that requester wins.
    - Both valid: the requester not equal to last_grant wins. Reset value makes IFU win first.
  - Winner's req_ready = 1 combinationally in IDLE; loser's req_ready = 0.
  - On handshake:
    - Latch addr, wen, wdata, wmask (IFU: wen = 0, wmask = 0, wdata = 0).
    - Set owner = winner and last_grant = winner; clear the counter.
    - Go to REQ.
- REQ:
  - mem_req_valid = 1 with latched fields stable until mem_req_ready.
  - On mem_req_ready: go to WAIT.
  - mem_rsp_valid in the same cycle as mem_req_ready is not accepted; the response is taken from the WAIT state only.
- WAIT:
  - On mem_rsp_valid, at the next edge:
    - owner rsp_valid = 1.
    - rsp_data = mem_rsp_data (LSU write: 0).
    - rsp_err = 0.
    - Go to IDLE.
- Watchdog:
  - The counter increments every cycle in REQ and WAIT.
  - If counter == TIMEOUT-1 and the exit condition of the current state has not occurred:
    - Drop mem_req_valid.
    - At the next edge: owner rsp_valid = 1, rsp_err = 1, rsp_data = 0.
    - Go to IDLE.
  - A real response and the timeout in the same cycle: the real response wins.
- Response outputs:
  - Registered; rsp_valid is high exactly one cycle. The non-owner's rsp signals stay 0.
  - The response cycle is an IDLE cycle, so a new req_ready may coincide with rsp_valid.
- Latency:
  - Handshake at T, mem_req_ready at T+1, mem_rsp_valid at T+2 → rsp_valid at T+3.
  - Minimum 3 cycles from accept to response.
- Ignored inputs:
  - mem_rsp_valid in IDLE or REQ (stray responses).
  - Requests while busy; req_ready = 0 and the requester must hold valid.
- Reset mid-transaction:
  - The transaction is dropped and no response is issued.
  - Requesters re-issue after reset.

Test Plan:
- Single IFU read, addr = 0x8000_0000:
  - ifu_req_ready at T; mem_req_valid with mem_addr = 0x8000_0000, mem_wen = 0 at T+1.
  - mem_rsp_data = 0x0000_0000_0041_0113 at T+2 → ifu_rsp_valid at T+3 with that data, err = 0; lsu_rsp_valid stays 0.
- Both requesters valid continuously from reset:
  - Grants alternate IFU, LSU, IFU, LSU (check the ready order over 4 transactions).
  - busy = 0 only on response cycles.
- LSU write, addr = 0x8000_0010, wdata = 0x1122_3344_5566_7788, wmask = 8'h0F:
  - mem_wen = 1 with identical wdata/wmask.
  - Fields held stable while mem_req_ready is delayed by 5 cycles.
  - lsu_rsp_valid follows with data 0.
- Timeout with TIMEOUT = 16, memory never responds:
  - mem_req_valid drops after 16 cycles in REQ+WAIT.
  - ifu_rsp_valid = 1, err = 1, data = 0; the next request is accepted normally.
- Stray mem_rsp_valid in IDLE → no rsp_valid on either side.
- Simultaneous mem_rsp_valid and timeout cycle → err = 0, data forwarded.
- Assert rst in WAIT:
  - Outputs are 0 immediately (asynchronously) and no response appears later.
  - After release, IFU wins the first contested grant.
